// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding, frame bit counts and baud divisor helper shared by the TX and RX paths
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;

    // Rounded to the nearest whole clock count per bit.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - parser-to-transmitter byte handshake (start/data/ready)
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic                 tx_start_i;
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_ready_o;

    modport master (
        output tx_start_i,
        output tx_data_i,
        input  tx_ready_o
    );

    modport slave (
        input  tx_start_i,
        input  tx_data_i,
        output tx_ready_o
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through read and extra-bit pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      wptr_d;
    logic [AW:0]      rptr_q;
    logic [AW:0]      rptr_d;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bit means the writer lapped the reader.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               bus,
    output logic                        tx_serial_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [2:0]    IDX_MAX = 3'(DATA_BITS - 1);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [2:0]           idx_q;
    logic [2:0]           idx_d;
    logic [DATA_BITS-1:0] sh_q;
    logic [DATA_BITS-1:0] sh_d;
    logic                 tx_serial_q;
    logic                 line_d;
    logic                 overflow_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 bit_end;

    assign fifo_push      = bus.tx_start_i && !fifo_full;
    assign bus.tx_ready_o = !fifo_full;
    assign bit_end        = (cnt_q == CNT_MAX);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (bus.tx_data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    // line_d is the level for the current state; registering it delays the pin one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        fifo_pop = 1'b0;
        line_d   = 1'b1;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                line_d = 1'b0;
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                line_d = sh_q[idx_q];
                if (bit_end) begin
                    if (idx_q == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                line_d = ^sh_q;
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                line_d = 1'b1;
                if (bit_end) begin
                    // Chain straight into the next start bit so bursts have no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_rdata;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            tx_serial_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            tx_serial_q <= line_d;
            if (bus.tx_start_i && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx_serial_o = tx_serial_q;
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a line-decoding monitor
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DEPTH    = 4;
    localparam int DIV      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_serial;
    logic       busy;
    logic       overflow;
    logic [2:0] level;

    uart_tx_fifo_if bus();

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .tx_serial_o  (tx_serial),
        .busy_o       (busy),
        .fifo_level_o (level),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    bit         abort = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        int g = 0;
        bus.tx_start_i = 1'b1;
        bus.tx_data_i  = b;
        while (bus.tx_ready_o !== 1'b1 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            check("send_timeout", 0, 1);
            acc = cyc;
        end else begin
            @(negedge clk);
            acc = cyc;
            exp_q.push_back(b);
        end
        bus.tx_start_i = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 20 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", int'(g < 20 * FRAME), 1);
        repeat (DIV) @(negedge clk);
    endtask

    task automatic wait_start(input int n, output int f);
        int g = 0;
        while (starts.size() <= n && g < 4 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check("start_seen", int'(starts.size() > n), 1);
        f = (starts.size() > n) ? starts[n] : cyc;
    endtask

    // Independent UART receiver: samples each bit at its middle and scores the decoded byte.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic       s0;
        logic       s1;
`ifdef UART_TX_PARITY_EN
        logic       p;
`endif
        forever begin
            @(negedge clk);
            if (!rst && tx_serial === 1'b0) begin
                starts.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                s0 = tx_serial;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx_serial;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                p = tx_serial;
`endif
                repeat (DIV) @(negedge clk);
                s1 = tx_serial;
                if (abort) begin
                    abort = 1'b0;
                    exp_q.delete();
                end else if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("start_bit", int'(s0), 0);
                    check("data_byte", int'(b), int'(e));
                    check("stop_bit", int'(s1), 1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", int'(p), $countones(e) % 2);
`endif
                end
            end
        end
    end

    initial begin
        int         a;
        int         t;
        int         f;
        int         n0;
        logic [7:0] r;

        bus.tx_start_i = 1'b0;
        bus.tx_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_line", int'(tx_serial), 1);
        check("rst_ready", int'(bus.tx_ready_o), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_level", int'(level), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single byte: latency and busy window
        n0 = starts.size();
        send(8'hA5, a);
        wait_start(n0, f);
        check("latency", f - a, 2);
        while (cyc < f + FRAME - 2) @(negedge clk);
        check("busy_in_stop", int'(busy), 1);
        while (cyc < f + FRAME) @(negedge clk);
        check("busy_after_stop", int'(busy), 0);
        drain();

        // burst: frames back to back
        n0 = starts.size();
        send(8'h55, t);
        send(8'h0F, t);
        send(8'hF0, t);
        send(8'h80, t);
        drain();
        check("burst_frames", starts.size() - n0, 4);
        for (int i = 1; i < 4; i++) begin
            check("burst_gap", starts[n0 + i] - starts[n0 + i - 1], FRAME);
        end
        check("no_overflow_yet", int'(overflow), 0);

        // fill while a frame is on the line, then overflow
        send(8'h11, a);
        repeat (3) @(negedge clk);
        send(8'h22, t);
        send(8'h33, t);
        send(8'h44, t);
        send(8'h66, t);
        check("full_level", int'(level), 4);
        check("full_ready", int'(bus.tx_ready_o), 0);
        check("full_no_overflow", int'(overflow), 0);
        bus.tx_start_i = 1'b1;
        bus.tx_data_i  = 8'hEE;
        @(negedge clk);
        check("overflow_set", int'(overflow), 1);
        send(8'hEE, t);
        check("refill_edge", t, a + FRAME + 2);
        check("refill_level", int'(level), 4);
        drain();
        check("overflow_sticky", int'(overflow), 1);

        // push on the same edge that STOP pops
        send(8'h3C, a);
        send(8'h5A, t);
        while (cyc < a + FRAME) @(negedge clk);
        check("pp_level_before", int'(level), 1);
        send(8'hC3, t);
        check("pp_edge", t, a + FRAME + 1);
        check("pp_level_after", int'(level), 1);
        drain();

`ifdef UART_TX_PARITY_EN
        n0 = starts.size();
        send(8'h07, t);
        send(8'h03, t);
        drain();
        check("parity_frame_gap", starts[n0 + 1] - starts[n0], 11 * DIV);
`endif

        // randomized bytes with random gaps
        for (int i = 0; i < 12; i++) begin
            r = 8'($urandom);
            send(r, t);
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        // reset in the middle of data bit 3 of 0xC3 with a second byte buffered
        send(8'hC3, a);
        send(8'h3C, t);
        while (cyc < a + 2 + 4 * DIV + 3) @(negedge clk);
        check("line_before_rst", int'(tx_serial), 0);
        abort = 1'b1;
        rst   = 1'b1;
        #1;
        check("rst_line_now", int'(tx_serial), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", int'(level), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_overflow", int'(overflow), 0);
        check("post_rst_ready", int'(bus.tx_ready_o), 1);
        n0 = starts.size();
        repeat (3 * FRAME) @(negedge clk);
        check("no_frame_after_rst", starts.size() - n0, 0);
        check("rst_discard", exp_q.size(), 0);
        check("post_rst_line", int'(tx_serial), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
